// File: rtl/pipe_stage_skid_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_if
// Valid/ready bus carrying a payload and its PC sideband between two pipeline
// stages. One instance is used per side of the stage.
//   valid : producer presents an entry
//   ready : consumer can accept
//   data  : payload (DATA_W bits)
//   pc    : PC sideband (PC_W bits)
// Modports:
//   master : producer side (drives valid/data/pc, samples ready)
//   slave  : consumer side (samples valid/data/pc, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_skid_if #(
    parameter int DATA_W = 96,
    parameter int PC_W   = 32
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;

    modport master (output valid, output data, output pc, input ready);
    modport slave  (input valid, input data, input pc, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Inter-stage pipeline register with a 2-entry skid buffer. Sustains one
// transfer per cycle under backpressure while keeping the upstream ready a
// registered signal. Supports a synchronous flush that kills held entries but
// captures the incoming PC, and keeps saturating stall/flush counters.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous reset, active-low
//   i_up         : upstream bus (slave modport); ready == !skid_valid, registered
//   o_dn         : downstream bus (master modport); driven straight from the
//                  main register
//   i_flush      : synchronous kill of all held entries
//   o_stall_cnt  : cycles with an entry held and downstream not ready
//   o_flush_cnt  : flush cycles that killed at least one valid entry
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int DATA_W = 96,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_stage_skid_if.slave      i_up,
    pipe_stage_skid_if.master     o_dn,
    input  logic                  i_flush,
    output logic [CNT_W-1:0]      o_stall_cnt,
    output logic [CNT_W-1:0]      o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [PC_W-1:0]   r_main_pc;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [PC_W-1:0]   r_skid_pc;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_in_fire;
    logic              w_out_fire;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign w_in_fire  = i_up.valid & r_in_ready;
    assign w_out_fire = r_main_valid & o_dn.ready;

    assign i_up.ready  = r_in_ready;
    assign o_dn.valid  = r_main_valid;
    assign o_dn.data   = r_main_data;
    assign o_dn.pc     = r_main_pc;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // Occupancy FSM, storage registers and performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_main_data  <= {DATA_W{1'b0}};
            r_main_pc    <= {PC_W{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_data  <= {DATA_W{1'b0}};
            r_skid_pc    <= {PC_W{1'b0}};
            r_in_ready   <= 1'b1;
            r_stall_cnt  <= {CNT_W{1'b0}};
            r_flush_cnt  <= {CNT_W{1'b0}};
        end else if (i_flush) begin
            // Kill everything, but keep the PC of the incoming slot so the
            // exception logic can see where the pipeline was redirected from.
            r_state      <= ST_EMPTY;
            r_main_valid <= 1'b0;
            r_main_data  <= {DATA_W{1'b0}};
            r_main_pc    <= i_up.pc;
            r_skid_valid <= 1'b0;
            r_skid_data  <= {DATA_W{1'b0}};
            r_skid_pc    <= {PC_W{1'b0}};
            r_in_ready   <= 1'b1;
            if (r_main_valid | r_skid_valid) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end else begin
            if (r_main_valid & ~o_dn.ready) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state      <= ST_ONE;
                        r_main_valid <= 1'b1;
                        r_main_data  <= i_up.data;
                        r_main_pc    <= i_up.pc;
                    end else begin
                        r_state      <= ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: begin
                            r_main_data  <= i_up.data;
                            r_main_pc    <= i_up.pc;
                        end
                        2'b10: begin
                            // Downstream stalled: park the new entry in skid
                            // and drop ready for the following cycle.
                            r_state      <= ST_FULL;
                            r_skid_valid <= 1'b1;
                            r_skid_data  <= i_up.data;
                            r_skid_pc    <= i_up.pc;
                            r_in_ready   <= 1'b0;
                        end
                        2'b01: begin
                            // Drain to empty; data/pc keep their last values.
                            r_state      <= ST_EMPTY;
                            r_main_valid <= 1'b0;
                        end
                        default: begin
                            r_state      <= ST_ONE;
                        end
                    endcase
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_state      <= ST_ONE;
                        r_main_data  <= r_skid_data;
                        r_main_pc    <= r_skid_pc;
                        r_skid_valid <= 1'b0;
                        r_skid_data  <= {DATA_W{1'b0}};
                        r_skid_pc    <= {PC_W{1'b0}};
                        r_in_ready   <= 1'b1;
                    end else begin
                        r_state      <= ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    r_state      <= ST_EMPTY;
                    r_main_valid <= 1'b0;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Directed bench for pipe_stage_skid (CNT_W=4 so saturation is reachable).
// Accepted entries are queued as expected outputs; a forked monitor pops and
// compares on every downstream transfer. Directed checks cover reset, fill,
// streaming, flush, counter saturation and reset-during-flush.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;
    localparam int DATA_W = 96;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_stage_skid_if #(.DATA_W(DATA_W), .PC_W(PC_W)) u_in  ();
    pipe_stage_skid_if #(.DATA_W(DATA_W), .PC_W(PC_W)) u_out ();

    pipe_stage_skid #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_up        (u_in),
        .o_dn        (u_out),
        .i_flush     (flush),
        .o_stall_cnt (stall_cnt),
        .o_flush_cnt (flush_cnt)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } entry_t;

    entry_t exp_q[$];
    int     n_checks;
    int     n_fail;
    int     n_pops;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p);
        u_in.valid = v;
        u_in.data  = d;
        u_in.pc    = p;
    endtask

    initial begin
        entry_t e;
        int     pops0;
        n_checks = 0;
        n_fail   = 0;
        n_pops   = 0;
        rst      = 1'b0;
        flush    = 1'b0;
        u_out.ready = 1'b0;
        drive(1'b0, 96'h0, 32'h1234);

        fork
            // Scoreboard monitor: pop on delivery, push on accept.
            forever begin
                @(negedge clk);
                if (!rst || flush) begin
                    exp_q.delete();
                end else begin
                    if (u_out.valid && u_out.ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", 128'(u_out.data), 128'h0);
                            chk("unexpected_output_q", 128'(1), 128'(0));
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", 128'(u_out.data), 128'(e.data));
                            chk("out_pc", 128'(u_out.pc), 128'(e.pc));
                        end
                        n_pops++;
                    end
                    if (u_in.valid && u_in.ready) begin
                        exp_q.push_back('{data: u_in.data, pc: u_in.pc});
                    end
                end
            end
        join_none

        // Reset for two cycles; in_pc must be ignored.
        step(); step();
        chk("rst_out_valid", 128'(u_out.valid), 128'(0));
        chk("rst_in_ready", 128'(u_in.ready), 128'(1));
        chk("rst_out_pc", 128'(u_out.pc), 128'(0));
        chk("rst_out_data", 128'(u_out.data), 128'(0));
        chk("rst_stall", 128'(stall_cnt), 128'(0));
        chk("rst_flush", 128'(flush_cnt), 128'(0));

        // Pass-through with one cycle latency.
        rst = 1'b1;
        u_out.ready = 1'b1;
        drive(1'b1, 96'hA, 32'h3000);
        step();
        drive(1'b0, 96'h0, 32'h0);
        chk("pt_out_valid", 128'(u_out.valid), 128'(1));
        chk("pt_out_data", 128'(u_out.data), 128'hA);
        chk("pt_out_pc", 128'(u_out.pc), 128'h3000);
        chk("pt_stall", 128'(stall_cnt), 128'(0));
        step();
        chk("pt_drained", 128'(u_out.valid), 128'(0));
        chk("pt_hold_data", 128'(u_out.data), 128'hA);

        // Backpressure fill into the skid register.
        u_out.ready = 1'b0;
        drive(1'b1, 96'h1, 32'h3004);
        step();
        drive(1'b1, 96'h2, 32'h3008);
        step();
        drive(1'b0, 96'h0, 32'h0);
        chk("bp_out_data", 128'(u_out.data), 128'h1);
        chk("bp_in_ready", 128'(u_in.ready), 128'(0));
        chk("bp_stall1", 128'(stall_cnt), 128'(1));
        step(); step();
        chk("bp_stall3", 128'(stall_cnt), 128'(3));
        chk("bp_hold_data", 128'(u_out.data), 128'h1);
        u_out.ready = 1'b1;
        step();
        chk("bp_second", 128'(u_out.data), 128'h2);
        chk("bp_second_pc", 128'(u_out.pc), 128'h3008);
        chk("bp_ready_back", 128'(u_in.ready), 128'(1));
        chk("bp_stall_kept", 128'(stall_cnt), 128'(3));
        step();
        chk("bp_empty", 128'(u_out.valid), 128'(0));
        chk("bp_queue", 128'(exp_q.size()), 128'(0));

        // Streaming 16 back-to-back entries.
        pops0 = n_pops;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 96'(i), 32'h4000 + 32'(4 * i));
            step();
            chk("st_in_ready", 128'(u_in.ready), 128'(1));
            chk("st_out_valid", 128'(u_out.valid), 128'(1));
        end
        drive(1'b0, 96'h0, 32'h0);
        step(); step();
        chk("st_count", 128'(n_pops - pops0), 128'(16));
        chk("st_queue", 128'(exp_q.size()), 128'(0));

        // Flush while FULL.
        u_out.ready = 1'b0;
        drive(1'b1, 96'h11, 32'h3010);
        step();
        drive(1'b1, 96'h22, 32'h3014);
        step();
        chk("fl_full", 128'(u_in.ready), 128'(0));
        chk("fl_stall4", 128'(stall_cnt), 128'(4));
        drive(1'b1, 96'h33, 32'h3040);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 96'h0, 32'h0);
        chk("fl_out_valid", 128'(u_out.valid), 128'(0));
        chk("fl_in_ready", 128'(u_in.ready), 128'(1));
        chk("fl_out_pc", 128'(u_out.pc), 128'h3040);
        chk("fl_out_data", 128'(u_out.data), 128'h0);
        chk("fl_cnt1", 128'(flush_cnt), 128'(1));
        chk("fl_stall_kept", 128'(stall_cnt), 128'(4));

        // Flush while EMPTY with a coincident accept: accept discarded, count unchanged.
        drive(1'b1, 96'h44, 32'h3060);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 96'h0, 32'h0);
        chk("fe_out_valid", 128'(u_out.valid), 128'(0));
        chk("fe_out_pc", 128'(u_out.pc), 128'h3060);
        chk("fe_cnt", 128'(flush_cnt), 128'(1));

        // Stall counter saturation at 15.
        drive(1'b1, 96'h55, 32'h3070);
        step();
        drive(1'b0, 96'h0, 32'h0);
        for (int i = 0; i < 5; i++) step();
        chk("sat_mid", 128'(stall_cnt), 128'(9));
        for (int i = 0; i < 15; i++) step();
        chk("sat_top", 128'(stall_cnt), 128'(15));
        u_out.ready = 1'b1;
        step();
        chk("sat_hold", 128'(stall_cnt), 128'(15));
        chk("sat_drained", 128'(u_out.valid), 128'(0));

        // Reset together with flush while FULL: reset wins.
        u_out.ready = 1'b0;
        drive(1'b1, 96'h66, 32'h3080);
        step();
        drive(1'b1, 96'h77, 32'h3084);
        step();
        chk("rf_full", 128'(u_in.ready), 128'(0));
        drive(1'b0, 96'h0, 32'h3090);
        rst   = 1'b0;
        flush = 1'b1;
        step();
        rst   = 1'b1;
        flush = 1'b0;
        chk("rf_out_valid", 128'(u_out.valid), 128'(0));
        chk("rf_in_ready", 128'(u_in.ready), 128'(1));
        chk("rf_out_data", 128'(u_out.data), 128'(0));
        chk("rf_out_pc", 128'(u_out.pc), 128'(0));
        chk("rf_stall", 128'(stall_cnt), 128'(0));
        chk("rf_flush", 128'(flush_cnt), 128'(0));
        step();
        chk("final_queue", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
